// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with its own baud-tick generator.
// Sends one DBIT-wide word per frame, framed as: start bit, data bits LSB first,
// an optional parity bit, then the stop period.
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_tx_start     request to send i_tx_data; accepted when o_tx_ready is high
//   i_tx_data      word to transmit; latched when it is accepted
//   o_tx_ready     high while idle and able to accept a word
//   o_tx_done_tick one-cycle pulse on the first idle cycle after a frame
//   o_busy         high while a frame is in progress (~o_tx_ready)
//   o_tx           serial line; idle high; driven from a flop
module uart_tx_core #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 1,
  parameter int DVSR_BIT = 4,
  parameter int PARITY   = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_tx_data,
  output logic            o_tx_ready,
  output logic            o_tx_done_tick,
  output logic            o_busy,
  output logic            o_tx
);

  localparam int TW = $clog2((SB_TICK > 16) ? SB_TICK : 16) + 1;
  localparam int BW = $clog2(DBIT) + 1;
  // Parity settings other than 1 and 2 select no parity.
  localparam bit HasParity = (PARITY == 1) || (PARITY == 2);

  localparam logic [DVSR_BIT-1:0] DivLast  = DVSR_BIT'(DVSR);
  localparam logic [DVSR_BIT-1:0] DivPre   = DVSR_BIT'(DVSR - 1);
  localparam logic [TW-1:0]       BitLast  = TW'(15);
  localparam logic [TW-1:0]       StopLast = TW'(SB_TICK - 1);
  localparam logic [TW-1:0]       StopPre  = TW'(SB_TICK - 2);
  localparam logic [BW-1:0]       DataLast = BW'(DBIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state;
  logic [DVSR_BIT-1:0] div;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shreg;
  logic [DBIT-1:0] shnext;
  logic            par;
  logic            tick;
  logic            bit_end;
  logic            stop_end;

  always_comb begin
    tick    = (state != StIdle) && (div == DivLast);
    bit_end = tick && (tick_cnt == BitLast);
    shnext  = shreg >> 1;
    // Leave STOP one clock early. The final stop tick then lands on the first
    // idle cycle. That cycle carries the done pulse and can already accept the
    // next word, so back-to-back frames have no gap.
    if (DVSR == 0) begin
      stop_end = tick && (tick_cnt == StopPre);
    end else begin
      stop_end = (div == DivPre) && (tick_cnt == StopLast);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= StIdle;
      div            <= '0;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      par            <= 1'b0;
      o_tx           <= 1'b1;
      o_tx_ready     <= 1'b1;
      o_tx_done_tick <= 1'b0;
    end else begin
      o_tx_done_tick <= 1'b0;
      if (state != StIdle) begin
        div <= tick ? '0 : div + 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (i_tx_start) begin
            state      <= StStart;
            shreg      <= i_tx_data;
            par        <= (PARITY == 2) ? ~^i_tx_data : ^i_tx_data;
            div        <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            o_tx       <= 1'b0;
            o_tx_ready <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state    <= StData;
            tick_cnt <= '0;
            o_tx     <= shreg[0];
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_cnt == DataLast) begin
              if (HasParity) begin
                state <= StParity;
                o_tx  <= par;
              end else begin
                state <= StStop;
                o_tx  <= 1'b1;
              end
            end else begin
              shreg   <= shnext;
              bit_cnt <= bit_cnt + 1'b1;
              o_tx    <= shnext[0];
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        StParity: begin
          if (bit_end) begin
            state    <= StStop;
            tick_cnt <= '0;
            o_tx     <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        StStop: begin
          if (stop_end) begin
            state          <= StIdle;
            div            <= '0;
            tick_cnt       <= '0;
            o_tx_done_tick <= 1'b1;
            o_tx_ready     <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy = ~o_tx_ready;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core. Four instances share clock and reset:
//   0: defaults; 1: even parity; 2: odd parity; 3: SB_TICK=32.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic       start [4];
  logic [7:0] data  [4];
  logic       tx    [4];
  logic       rdy   [4];
  logic       dn    [4];
  logic       bsy   [4];

  int checks   = 0;
  int failures = 0;

  uart_tx_core u_d0 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start[0]), .i_tx_data(data[0]),
    .o_tx_ready(rdy[0]), .o_tx_done_tick(dn[0]), .o_busy(bsy[0]), .o_tx(tx[0])
  );

  uart_tx_core #(.PARITY(1)) u_d1 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start[1]), .i_tx_data(data[1]),
    .o_tx_ready(rdy[1]), .o_tx_done_tick(dn[1]), .o_busy(bsy[1]), .o_tx(tx[1])
  );

  uart_tx_core #(.PARITY(2)) u_d2 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start[2]), .i_tx_data(data[2]),
    .o_tx_ready(rdy[2]), .o_tx_done_tick(dn[2]), .o_busy(bsy[2]), .o_tx(tx[2])
  );

  uart_tx_core #(.SB_TICK(32)) u_d3 (
    .i_clk(clk), .i_reset(rst), .i_tx_start(start[3]), .i_tx_data(data[3]),
    .o_tx_ready(rdy[3]), .o_tx_done_tick(dn[3]), .o_busy(bsy[3]), .o_tx(tx[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word on a negedge so the following posedge accepts it.
  task automatic launch(input int idx, input logic [7:0] word);
    @(negedge clk);
    data[idx]  = word;
    start[idx] = 1'b1;
  endtask

  // Follow one frame from the cycle after acceptance (k=1) to the done cycle (k=L).
  // par_bit < 0 means no parity bit. After the k=1 sample the start/data inputs
  // are set to next_start/next_data; start drops at k == drop_at.
  task automatic run_frame(input int idx, input logic [7:0] word, input int par_bit,
                           input int stop_clk, input logic next_start,
                           input logic [7:0] next_data, input int drop_at,
                           input string tag);
    logic [9:0] lv;
    int nbits;
    int len;
    int b;
    int done_cnt;
    int done_at;
    logic ready_bad;
    lv        = {(par_bit == 1), word, 1'b0};
    nbits     = (par_bit < 0) ? 9 : 10;
    len       = nbits * 32 + stop_clk;
    done_cnt  = 0;
    done_at   = -1;
    ready_bad = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k <= nbits * 32) begin
        b = (k - 1) / 32;
        if (((k - 1) % 32 == 0) || ((k - 1) % 32 == 31)) begin
          check($sformatf("%s_bit%0d_k%0d", tag, b, k), 32'(tx[idx]), 32'(lv[b]));
        end
      end else if ((k == nbits * 32 + 1) || (k == len)) begin
        check($sformatf("%s_stop_k%0d", tag, k), 32'(tx[idx]), 32'd1);
      end
      if (dn[idx]) begin
        done_cnt++;
        done_at = k;
      end
      if ((k < len) && (rdy[idx] !== 1'b0)) ready_bad = 1'b1;
      if (k == 1) begin
        start[idx] = next_start;
        data[idx]  = next_data;
      end
      if (k == drop_at) start[idx] = 1'b0;
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(len));
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({tag, "_ready_end"}, 32'(rdy[idx]), 32'd1);
    check({tag, "_busy_end"}, 32'(bsy[idx]), 32'd0);
  endtask

  // Watch an idle instance: line high, ready high, no done pulse.
  task automatic idle_watch(input int idx, input int cycles, input string tag);
    int dcnt;
    logic tx_bad;
    logic rdy_bad;
    dcnt    = 0;
    tx_bad  = 1'b0;
    rdy_bad = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (dn[idx]) dcnt++;
      if (tx[idx] !== 1'b1) tx_bad = 1'b1;
      if (rdy[idx] !== 1'b1) rdy_bad = 1'b1;
    end
    check({tag, "_no_done"}, 32'(dcnt), 32'd0);
    check({tag, "_tx_high"}, 32'(tx_bad), 32'd0);
    check({tag, "_ready_high"}, 32'(rdy_bad), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);

    // Reset state of every instance.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
      check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
    end
    rst = 1'b0;
    idle_watch(0, 5, "post_rst");

    // 0x55, defaults: 320 clocks to the done pulse.
    launch(0, 8'h55);
    run_frame(0, 8'h55, -1, 32, 1'b0, 8'h00, 0, "f55");
    idle_watch(0, 10, "after55");

    // 0xA5 then 0x3C with start held high; data changes right after acceptance.
    launch(0, 8'hA5);
    run_frame(0, 8'hA5, -1, 32, 1'b1, 8'h3C, 0, "b2b_a5");
    run_frame(0, 8'h3C, -1, 32, 1'b0, 8'h3C, 0, "b2b_3c");
    idle_watch(0, 10, "after_b2b");

    // Even and odd parity on 0x07 (three ones): bits 1 and 0, 352 clocks.
    launch(1, 8'h07);
    run_frame(1, 8'h07, 1, 32, 1'b0, 8'h00, 0, "even07");
    launch(2, 8'h07);
    run_frame(2, 8'h07, 0, 32, 1'b0, 8'h00, 0, "odd07");

    // Two stop bits: 64 stop clocks, done at 352.
    launch(3, 8'hFF);
    run_frame(3, 8'hFF, -1, 64, 1'b0, 8'h00, 0, "sb32_ff");

    // Start request with 0x12 while 0x34 is in flight is ignored.
    launch(0, 8'h34);
    run_frame(0, 8'h34, -1, 32, 1'b1, 8'h12, 200, "busy34");
    idle_watch(0, 40, "no12");

    // Reset in the middle of the data bits of a 0x00 frame.
    launch(0, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) start[0] = 1'b0;
    end
    check("mid_data_tx", 32'(tx[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx[0]), 32'd1);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_done", 32'(dn[0]), 32'd0);
    rst = 1'b0;
    idle_watch(0, 300, "post_abort");

    launch(0, 8'h81);
    run_frame(0, 8'h81, -1, 32, 1'b0, 8'h00, 0, "f81");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
